// File: rtl/pipe_share_arbiter.sv
// pipe_share_arbiter
//   Shares one fixed-latency, non-stallable datapath among NUM_REQ requesters.
//   A round-robin arbiter grants at most one request per cycle into the datapath.
//   The requester ID travels beside the data in a tag shift register.
//   Results land in a show-ahead response FIFO.
//   Issue is credit-limited: in-flight plus buffered entries never exceed
//   RSP_DEPTH, so a result is never dropped while the consumer back-pressures.
//
//   Optional build macro: PIPE_SHARE_STATS_EN adds the issue and credit-stall
//   counters. When it is undefined, both stat ports read 0 and no counter flops
//   are built.
//
//   Handshake: a request transfers in a cycle where req_valid[i] & req_ready[i].
//   A requester holds req_valid and its data stable until that transfer, or it
//   may withdraw req_valid before any transfer. A response pops in a cycle where
//   rsp_valid & rsp_ready. rsp_valid does not depend on rsp_ready.
module pipe_share_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 32,
  parameter  int LATENCY   = 3,
  parameter  int RSP_DEPTH = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pipe_in_valid,
  output logic [DATA_W-1:0]         pipe_in_data,
  input  logic [DATA_W-1:0]         pipe_out_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [31:0]               stat_issue_cnt,
  output logic [31:0]               stat_stall_cnt
);

  localparam int                CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam int                PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

  // Credit and arbitration state
  logic [CNT_W-1:0]  r_used;
  logic [ID_W-1:0]   r_last;

  // Tag pipeline, aligned with the datapath stages
  logic [LATENCY-1:0] r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [LATENCY];

  // Response FIFO
  logic [ID_W-1:0]   r_fifo_id   [RSP_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fifo_cnt;

  logic              w_can_issue;
  logic              w_grant_found;
  logic [ID_W-1:0]   w_grant_idx;
  logic [ID_W-1:0]   w_cand;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;

  // A credit returned by a pop is usable only from the next cycle.
  // Reset also blocks issue, so nothing is accepted that reset would discard.
  assign w_can_issue = !rst && (r_used < DEPTH_C);

  // Round-robin search starting one past the last granted requester
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_grant_found && req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  assign w_issue = w_can_issue && w_grant_found;

  // One-hot accept towards the granted requester and operand mux to the datapath
  always_comb begin
    req_ready     = '0;
    pipe_in_valid = w_issue;
    pipe_in_data  = '0;
    if (w_issue) begin
      req_ready[w_grant_idx] = 1'b1;
      pipe_in_data           = req_data[w_grant_idx*DATA_W +: DATA_W];
    end
  end

  // Last-grant pointer moves only on an actual transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= ID_LAST;
    end else if (w_issue) begin
      r_last <= w_grant_idx;
    end
  end

  // Occupancy: in-flight plus buffered; issue and pop together cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_used <= '0;
    end else if (w_issue && !w_pop) begin
      r_used <= r_used + CNT_W'(1);
    end else if (!w_issue && w_pop) begin
      r_used <= r_used - CNT_W'(1);
    end
  end

  // Tag valid shift; clearing it on reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
      end
    end
  end

  // Tag ID shift; meaningful only where the matching valid bit is set
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_grant_idx;
    for (int i = 1; i < LATENCY; i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign w_push       = r_tag_vld[LATENCY-1];
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = !w_fifo_empty && rsp_ready;

  // FIFO pointers and fill count; credits guarantee a free slot on every push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
      end
    end
  end

  // FIFO storage: capture the datapath result with its requester ID
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= r_tag_id[LATENCY-1];
      r_fifo_data[r_wr_ptr] <= pipe_out_data;
    end
  end

  // The show-ahead head is forced to zero while the FIFO is empty
  assign rsp_valid = !w_fifo_empty;
  assign rsp_id    = w_fifo_empty ? '0 : r_fifo_id[r_rd_ptr];
  assign rsp_data  = w_fifo_empty ? '0 : r_fifo_data[r_rd_ptr];

`ifdef PIPE_SHARE_STATS_EN
  logic [31:0] r_stat_issue;
  logic [31:0] r_stat_stall;

  // Issue count, plus cycles where someone is waiting but no credit is left
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issue <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_issue) begin
        r_stat_issue <= r_stat_issue + 32'd1;
      end
      if ((|req_valid) && !w_can_issue) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_issue_cnt = r_stat_issue;
  assign stat_stall_cnt = r_stat_stall;
`else
  assign stat_issue_cnt = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with a +1 datapath model of LATENCY stages.
module tb_pipe_share_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int LATENCY   = 3;
  localparam int RSP_DEPTH = 4;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      pipe_in_valid;
  logic [DATA_W-1:0]         pipe_in_data;
  logic [DATA_W-1:0]         pipe_out_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic [31:0]               stat_issue_cnt;
  logic [31:0]               stat_stall_cnt;

  logic [DATA_W-1:0]         dp_q [LATENCY];
  logic [ID_W+DATA_W-1:0]    exp_q [$];
  int                        checks   = 0;
  int                        failures = 0;
  int                        inflight = 0;

  pipe_share_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .LATENCY  (LATENCY),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .pipe_in_valid (pipe_in_valid),
    .pipe_in_data  (pipe_in_data),
    .pipe_out_data (pipe_out_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .stat_issue_cnt(stat_issue_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Datapath model: result = operand + 1, LATENCY cycles after issue
  always @(posedge clk) begin
    dp_q[0] <= pipe_in_data + 32'd1;
    for (int i = 1; i < LATENCY; i++) dp_q[i] <= dp_q[i-1];
  end
  assign pipe_out_data = dp_q[LATENCY-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and credit monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
    end else begin
      if (pipe_in_valid) check("credit_ok", 64'(inflight < RSP_DEPTH), 64'd1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_extra", 64'(exp_q.size()), 64'd1);
        else                   check("rsp", {rsp_id, rsp_data}, exp_q.pop_front());
      end
      inflight = inflight + int'(pipe_in_valid) - int'(rsp_valid && rsp_ready);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) next();
    check(tag, 64'(exp_q.size()), 64'd0);
    next();
    @(negedge clk);
    check({tag, "_empty"}, 64'(rsp_valid), 64'd0);
    next();
  endtask

  logic [NUM_REQ-1:0] b_exp [10];
  logic [NUM_REQ-1:0] c_exp [14];

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_ready",  64'(req_ready),     64'd0);
    check("rst_pin_v",  64'(pipe_in_valid), 64'd0);
    check("rst_pin_d",  64'(pipe_in_data),  64'd0);
    check("rst_rsp_v",  64'(rsp_valid),     64'd0);
    check("rst_rsp_id", 64'(rsp_id),        64'd0);
    check("rst_rsp_d",  64'(rsp_data),      64'd0);
    check("rst_stat_i", 64'(stat_issue_cnt), 64'd0);
    check("rst_stat_s", 64'(stat_stall_cnt), 64'd0);
    next();

    // A: single request from requester 2, response after LATENCY+1 cycles
    rsp_ready = 1'b1;
    set_req(2, 32'h10);
    req_valid = 4'b0100;
    @(negedge clk);
    check("a_ready", 64'(req_ready),     64'b0100);
    check("a_pin_v", 64'(pipe_in_valid), 64'd1);
    check("a_pin_d", 64'(pipe_in_data),  64'h10);
    exp_q.push_back({2'd2, 32'h11});
    next();
    req_valid = '0;
    @(negedge clk);
    check("a_idle_v", 64'(pipe_in_valid), 64'd0);
    check("a_idle_d", 64'(pipe_in_data),  64'd0);
    next();
    next();
    @(negedge clk);
    check("a_rsp_early", 64'(rsp_valid), 64'd0);
    next();
    @(negedge clk);
    check("a_rsp_v",  64'(rsp_valid), 64'd1);
    check("a_rsp_id", 64'(rsp_id),    64'd2);
    check("a_rsp_d",  64'(rsp_data),  64'h11);
    next();
    @(negedge clk);
    check("a_rsp_gone", 64'(rsp_valid), 64'd0);
    next();
    next();

    // B: requesters 1 and 3 alternate from last=2; 4 issues then a credit bubble
    b_exp = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0000,
              4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0000};
    set_req(1, 32'h100);
    set_req(3, 32'h300);
    req_valid = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("b_grant_c%0d", c), 64'(req_ready), 64'(b_exp[c]));
      if (b_exp[c] == 4'b1000) exp_q.push_back({2'd3, 32'h301});
      if (b_exp[c] == 4'b0010) exp_q.push_back({2'd1, 32'h101});
      next();
    end
    req_valid = '0;
    drain("b_drain");

    // C: all requesters, consumer stalled -> exactly 4 issues, then credit stall
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'hA0 + 32'(i));
    req_valid = 4'b1111;
    c_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check($sformatf("c_grant_c%0d", c), 64'(req_ready), 64'(c_exp[c]));
      if (c < 4) exp_q.push_back({2'(c), 32'hA1 + 32'(c)});
      next();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("c_pop_ready", 64'(req_ready), 64'd0);
    check("c_head_v",    64'(rsp_valid), 64'd1);
    check("c_head_id",   64'(rsp_id),    64'd0);
    check("c_head_d",    64'(rsp_data),  64'hA1);
`ifdef PIPE_SHARE_STATS_EN
    check("c_stat_issue", 64'(stat_issue_cnt), 64'd4);
    check("c_stat_stall", 64'(stat_stall_cnt), 64'd10);
`else
    check("c_stat_issue", 64'(stat_issue_cnt), 64'd0);
    check("c_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
    next();
    @(negedge clk);
    check("c_resume", 64'(req_ready),    64'b0001);
    check("c_resume_d", 64'(pipe_in_data), 64'hA0);
    exp_q.push_back({2'd0, 32'hA1});
    next();
    req_valid = '0;
    drain("c_drain");

    // D: reset while three requests are in flight discards them all
    set_req(3, 32'h33);
    req_valid = 4'b1000;
    @(negedge clk);
    check("d_g0", 64'(req_ready), 64'b1000);
    next();
    set_req(1, 32'h11);
    req_valid = 4'b0010;
    @(negedge clk);
    check("d_g1", 64'(req_ready), 64'b0010);
    next();
    set_req(2, 32'h22);
    req_valid = 4'b0100;
    @(negedge clk);
    check("d_g2", 64'(req_ready), 64'b0100);
    next();
    req_valid = '0;
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("d_no_rsp_c%0d", c), 64'(rsp_valid), 64'd0);
      next();
    end
    set_req(0, 32'h7F);
    req_valid = 4'b1111;
    @(negedge clk);
    check("d_first_grant", 64'(req_ready), 64'b0001);
    exp_q.push_back({2'd0, 32'h80});
    next();
    req_valid = '0;
    drain("d_drain");

    // E: requester 0 withdraws during a credit stall; last stays on requester 1
    rsp_ready = 1'b0;
    set_req(1, 32'h50);
    req_valid = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("e_fill_c%0d", c), 64'(req_ready), 64'b0010);
      exp_q.push_back({2'd1, 32'h51});
      next();
    end
    req_valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("e_stall_c%0d", c), 64'(req_ready), 64'd0);
      check($sformatf("e_stall_v%0d", c), 64'(pipe_in_valid), 64'd0);
      next();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    next();
    next();
    set_req(2, 32'h60);
    req_valid = 4'b0110;
    @(negedge clk);
    check("e_last_kept", 64'(req_ready), 64'b0100);
    exp_q.push_back({2'd2, 32'h61});
    next();
    req_valid = '0;
    drain("e_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_share_arbiter.md
Name: pipe_share_arbiter

Overview:
- Shares one fixed-latency, non-stallable datapath pipeline (for example the generated two-stage increment pipeline with a registered input stage) among NUM_REQ requesters.
- Round-robin grants at most one request per cycle into the pipeline, carries the requester ID alongside in a tag shift register, and captures results into a response FIFO.
- Credit-limits issue so a result is never dropped when the response consumer back-pressures.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_W, 32, datapath width
- LATENCY, 3, cycles from pipe_in_valid to matching pipe_out_data (>=1)
- RSP_DEPTH, 4, response FIFO entries; also the maximum in-flight plus buffered count (>=1)
- ID_W, $clog2(NUM_REQ), derived localparam, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- pipe_in_valid  out  1  issue strobe to the datapath
- pipe_in_data  out  DATA_W  operand to the datapath
- pipe_out_data  in  DATA_W  datapath result, valid LATENCY cycles after issue
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the head response
- rsp_data  out  DATA_W  head response data
- stat_issue_cnt  out  32  issue counter (optional feature)
- stat_stall_cnt  out  32  credit-stall counter (optional feature)

Behaviour:
- Occupancy counter `used`, range 0..RSP_DEPTH, counts in-flight plus buffered entries.
  - Increments on issue and decrements on pop (rsp_valid & rsp_ready).
  - Simultaneous issue and pop leave it unchanged.
- can_issue = (used < RSP_DEPTH), evaluated on the registered value; a pop does not free a credit until the next cycle.
- Arbitration:
  - Register `last` holds the index of the last grant.
  - Priority order is last+1, last+2, … with wrap modulo NUM_REQ.
  - The grant goes to the first requester with req_valid set.
  - req_ready[g] = can_issue & grant[g]; all other bits are 0. req_ready is combinational from req_valid, `last` and `used`.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold req_valid and data stable until the transfer.
  - A requester may drop req_valid without a transfer; nothing is issued for it.
- Issue: in the transfer cycle, pipe_in_valid=1 and pipe_in_data=req_data[g]. With no transfer, pipe_in_valid=0 and pipe_in_data=0. `last` updates to g only on transfer.
- Tag pipeline: LATENCY stages of {valid, id}. An issue in cycle t places the tag in the last stage during cycle t+LATENCY. When that tag is valid, {id, pipe_out_data} is written into the FIFO at the end of that cycle.
- Response FIFO:
  - Circular buffer with show-ahead head; rsp_valid = !empty.
  - rsp_id and rsp_data are 0 when empty.
  - Order is strictly issue order.
  - Overflow cannot occur by construction; the bench asserts this.
- Latency: issue to rsp_valid is LATENCY+1 cycles when the FIFO is empty. At defaults with rsp_ready=1, sustained throughput is 4 grants per 5 cycles.
- Reset values and effects:
  - used=0 and FIFO empty.
  - All tag valids are cleared; in-flight data is discarded and later pipe_out_data is ignored.
  - last=NUM_REQ-1, so requester 0 has first priority.
  - Outputs: req_ready=0, pipe_in_valid=0, pipe_in_data=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - Reset mid-operation takes effect the next cycle with no residual responses.

Optional Feature:
- Macro: PIPE_SHARE_STATS_EN.
- Defined:
  - stat_issue_cnt increments on each issue.
  - stat_stall_cnt increments each cycle where any req_valid is high and can_issue=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Requester 2 sends 0x10, datapath model is +1, cycle 0 -> req_ready=4'b0100 in cycle 0; rsp_valid in cycle 4 with rsp_id=2, rsp_data=0x11.
- Requesters 1 and 3 continuously valid, rsp_ready=1 -> grant order 1,3,1,3,…; requesters 0 and 2 never granted; pattern of 4 issues then 1 bubble.
- All requesters valid, rsp_ready=0 -> exactly 4 issues (ids 0,1,2,3), then req_ready=0 indefinitely. Raise rsp_ready -> responses pop in order 0,1,2,3; issue resumes the cycle after the first pop.
- Issue 3 requests, assert rst for 1 cycle at cycle 2 -> no rsp_valid ever appears for those requests; after reset the first grant goes to requester 0.
- Requester 0 raises valid then drops it before ready due to a credit stall -> no issue and no response for it; `last` unchanged.
- With PIPE_SHARE_STATS_EN, the rsp_ready=0 scenario held for 10 cycles after saturation -> stat_issue_cnt=4, stat_stall_cnt=10. Without the macro, both read 0.
